bit_deser5: RTL and testbench

BIT_DESER5 -- requirements
Module: bit_deser5

---
 rtl/deser_pkg.sv | 10 +
 rtl/demux_n.sv | 16 +
 rtl/bit_deser5.sv | 106 ++++++++++
 tb/tb_bit_deser5.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel deserializer.
// The state enum is used by the top level and by any bench that reads the state.
package deser_pkg;

   typedef enum logic {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

endpackage : deser_pkg

// File: rtl/demux_n.sv
// 1-to-N decoder: raises exactly one enable (the one selected by i_sel) while i_en is high.
// This is the structural mirror of an N:1 bit-select mux.
module demux_n #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [W-1:0] i_sel,
   input  logic         i_en,
   output logic [N-1:0] o_onehot
);

   for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign o_onehot[gi] = i_en && (i_sel == W'(gi));
   end

endmodule : demux_n

// File: rtl/bit_deser5.sv
// Serial-to-parallel deserializer: collects N bits LSB first, then holds the word
// until the consumer takes it. Handshake outputs are decoded from state only.
module bit_deser5
   import deser_pkg::*;
#(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         in_valid,
   input  logic         in_bit,
   output logic         in_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   input  logic         out_ready,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LAST_IDX = W'(N - 1);

   state_t         r_state;
   state_t         w_state_next;
   logic [W-1:0]   r_count;
   logic [W-1:0]   w_count_next;
   logic [N-1:0]   r_data;
   logic [N-1:0]   w_we;
   logic           w_in_xfer;
   logic           w_last;

   assign w_in_xfer = in_valid && in_ready;
   assign w_last    = (r_count == LAST_IDX);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; clear overrides any pending transfer
   always_comb begin
      w_state_next = r_state;
      if (clr) begin
         w_state_next = S_FILL;
      end else begin
         case (r_state)
            S_FILL:  if (w_in_xfer && w_last) w_state_next = S_HOLD;
            S_HOLD:  if (out_ready)           w_state_next = S_FILL;
            default:                          w_state_next = S_FILL;
         endcase
      end
   end

   // Handshake decode from the state register only
   always_comb begin
      in_ready  = (r_state == S_FILL);
      out_valid = (r_state == S_HOLD);
   end

   always_comb begin
      w_count_next = r_count;
      if (clr) begin
         w_count_next = '0;
      end else if (w_in_xfer) begin
         w_count_next = w_last ? '0 : r_count + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   demux_n #(
      .N (N),
      .W (W)
   ) u_demux (
      .i_sel    (r_count),
      .i_en     (w_in_xfer && !clr),
      .o_onehot (w_we)
   );

   // Unwritten bit positions keep their previous value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if (clr) begin
         r_data <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_we[k]) r_data[k] <= in_bit;
         end
      end
   end

   assign out_data = r_data;
   assign count    = r_count;

endmodule : bit_deser5

// File: tb/tb_bit_deser5.sv
// Bench for bit_deser5: a vector table for the basic fill/hold sequence, hand-written
// corner sequences, and a random run checked against a bit-queue reference model.
module tb_bit_deser5;

   localparam int N = 5;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst, clr, in_valid, in_bit, out_ready;
   logic         in_ready, out_valid;
   logic [N-1:0] out_data;
   logic [W-1:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model: number of bits collected for the current word (N means a full
   // word waiting for the consumer) and the last value of every bit position.
   int           m_n;
   logic [N-1:0] m_data;

   typedef struct {
      logic         iv, ib, ordy, cl;
      logic         exp_ir, exp_ov;
      logic [W-1:0] exp_cnt;
      logic [N-1:0] exp_data;
   } vec_t;
   vec_t vecs[$];

   bit_deser5 #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_n    = 0;
      m_data = '0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".in_ready"},  32'(in_ready),  32'(m_n != N));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_n == N));
      chk({tag, ".count"},     32'(count),     32'(m_n % N));
      chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
   endtask

   // One clock: inputs already driven, model advances at the edge, outputs checked 1ns later
   task automatic tick(input string tag);
      logic iv, ib, orr, cl;
      iv = in_valid; ib = in_bit; orr = out_ready; cl = clr;
      @(posedge clk);
      if (cl) begin
         model_clear();
      end else if (m_n == N) begin
         if (orr) m_n = 0;
      end else if (iv) begin
         m_data[m_n] = ib;
         m_n++;
      end
      #1;
      check_model(tag);
   endtask

   task automatic drive(input logic iv, input logic ib, input logic orr, input logic cl);
      in_valid = iv; in_bit = ib; out_ready = orr; clr = cl;
   endtask

   task automatic add_vec(input logic iv, ib, ordy, cl, ir, ov,
                          input logic [W-1:0] cnt, input logic [N-1:0] d);
      vec_t v;
      v = '{iv, ib, ordy, cl, ir, ov, cnt, d};
      vecs.push_back(v);
   endtask

   task automatic send_bits(input logic [N-1:0] bits, input string tag);
      for (int i = 0; i < N; i++) begin
         drive(1'b1, bits[i], 1'b0, 1'b0);
         tick(tag);
      end
   endtask

   initial begin
      logic [N-1:0] words[$];
      logic [9:0]   rbits;
      int           acc, idle;

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      #2;
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.count", 32'(count), 32'd0);
      chk("reset.out_data", 32'(out_data), 32'd0);
      #10 rst = 1'b0;

      // Fill 1,0,1,1,0, hold 10 cycles under in_valid, release, then retention and clear
      add_vec(1, 1, 0, 0, 1, 0, 3'd1, 5'b00001);
      add_vec(1, 0, 0, 0, 1, 0, 3'd2, 5'b00001);
      add_vec(1, 1, 0, 0, 1, 0, 3'd3, 5'b00101);
      add_vec(1, 1, 0, 0, 1, 0, 3'd4, 5'b01101);
      add_vec(1, 0, 0, 0, 0, 1, 3'd0, 5'b01101);
      for (int i = 0; i < 10; i++) add_vec(1, 1, 0, 0, 0, 1, 3'd0, 5'b01101);
      add_vec(1, 1, 1, 0, 1, 0, 3'd0, 5'b01101);
      add_vec(1, 0, 0, 0, 1, 0, 3'd1, 5'b01100);
      add_vec(0, 1, 1, 0, 1, 0, 3'd1, 5'b01100);
      add_vec(1, 1, 0, 1, 1, 0, 3'd0, 5'b00000);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].iv, vecs[i].ib, vecs[i].ordy, vecs[i].cl);
         tick("vec_model");
         chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
         chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      end

      // Gapped input: valid every other cycle, all ones
      for (int i = 0; i < 10; i++) begin
         drive((i % 2) == 0, 1'b1, 1'b0, 1'b0);
         tick("gapped");
         chk("gapped.count", 32'(count), 32'(((i / 2) + 1) % N));
      end
      chk("gapped.word", 32'(out_data), 32'h1f);
      chk("gapped.valid", 32'(out_valid), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick("gapped_out");

      // Asynchronous reset between edges at count=3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         tick("pre_rst");
      end
      chk("pre_rst.count", 32'(count), 32'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst.count", 32'(count), 32'd0);
      chk("async_rst.out_data", 32'(out_data), 32'd0);
      chk("async_rst.in_ready", 32'(in_ready), 32'd1);
      model_clear();
      #7 rst = 1'b0;
      send_bits(5'b10011, "post_rst");
      chk("post_rst.word", 32'(out_data), 32'h13);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick("post_rst_out");

      // Clear at count=4 with a valid bit, then clear in hold with out_ready=1
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         tick("pre_clr");
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      tick("clr_fill");
      chk("clr_fill.count", 32'(count), 32'd0);
      chk("clr_fill.out_valid", 32'(out_valid), 32'd0);
      send_bits(5'b10110, "pre_clr_hold");
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick("clr_hold");
      chk("clr_hold.in_ready", 32'(in_ready), 32'd1);
      chk("clr_hold.out_data", 32'(out_data), 32'd0);

      // Back-to-back: out_ready tied high, continuous valid, 10 random bits
      rbits = 10'($urandom);
      acc   = 0;
      idle  = 0;
      for (int t = 0; t < 11; t++) begin
         drive(1'b1, (acc < 10) ? rbits[acc] : 1'b0, 1'b1, 1'b0);
         if (in_ready) acc++;
         tick("b2b");
         if (out_valid) words.push_back(out_data);
         if (!in_ready && t < 10) idle++;
      end
      chk("b2b.words", 32'(words.size()), 32'd2);
      chk("b2b.idle", 32'(idle), 32'd1);
      if (words.size() == 2) begin
         chk("b2b.word0", 32'(words[0]), 32'(rbits[4:0]));
         chk("b2b.word1", 32'(words[1]), 32'(rbits[9:5]));
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick("b2b_end");

      // Random traffic against the model
      for (int t = 0; t < 400; t++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
               $urandom_range(0, 31) == 0);
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bit_deser5
